// File: rtl/cordic_rot_sched.sv
// cordic_rot_sched: two-client scheduler for the pipelined CORDIC core with tag tracking
// and credit-controlled per-client result FIFOs.
// Define CORDIC_SCHED_FIXED_PRIO_EN for fixed priority (client 0 wins ties); round-robin otherwise.
module cordic_rot_sched #(
    parameter int data_width   = 16,
    parameter int angle_width  = 20,
    parameter int pipe_latency = 16,
    parameter int res_depth    = 4
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         r0_valid,
    output logic                         r0_ready,
    input  logic signed [data_width-1:0] r0_x,
    input  logic signed [data_width-1:0] r0_y,
    input  logic [angle_width-1:0]       r0_angle,
    input  logic                         r1_valid,
    output logic                         r1_ready,
    input  logic signed [data_width-1:0] r1_x,
    input  logic signed [data_width-1:0] r1_y,
    input  logic [angle_width-1:0]       r1_angle,
    output logic                         r0_res_valid,
    input  logic                         r0_res_ready,
    output logic signed [data_width-1:0] r0_res_x,
    output logic signed [data_width-1:0] r0_res_y,
    output logic                         r1_res_valid,
    input  logic                         r1_res_ready,
    output logic signed [data_width-1:0] r1_res_x,
    output logic signed [data_width-1:0] r1_res_y,
    output logic                         core_enable,
    output logic signed [data_width-1:0] core_x_in,
    output logic signed [data_width-1:0] core_y_in,
    output logic [angle_width-1:0]       core_angle,
    input  logic signed [data_width-1:0] core_x_out,
    input  logic signed [data_width-1:0] core_y_out,
    output logic                         busy
);
    localparam int aw = $clog2(res_depth);
    localparam int cw = aw + 1;

    logic [cw-1:0] credit [2];
    logic [cw-1:0] wp [2];
    logic [cw-1:0] rp [2];
    logic signed [data_width-1:0] mem_x [2][res_depth];
    logic signed [data_width-1:0] mem_y [2][res_depth];
    logic [pipe_latency:0] tag_v;
    logic [pipe_latency:0] tag_id;
    logic [1:0] elig, gnt, hs, empty, pop, wr, res_ready;

    assign res_ready = {r1_res_ready, r0_res_ready};
    assign elig = {r1_valid && credit[1] != '0, r0_valid && credit[0] != '0};
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
    assign gnt = {elig[1] && !elig[0], elig[0]};
`else
    logic last_grant;
    assign gnt = {elig[1] && (!elig[0] || !last_grant), elig[0] && (!elig[1] || last_grant)};
    // remember the most recent winner so that ties alternate
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) last_grant <= 1'b1;
        else if (hs[0]) last_grant <= 1'b0;
        else if (hs[1]) last_grant <= 1'b1;
`endif
    assign hs = gnt & {2{nreset}};
    assign r0_ready = hs[0];
    assign r1_ready = hs[1];
    assign wr = {2{tag_v[pipe_latency]}} & {tag_id[pipe_latency], !tag_id[pipe_latency]};
    assign empty = {wp[1] == rp[1], wp[0] == rp[0]};
    assign pop = res_ready & ~empty;
    assign r0_res_valid = !empty[0];
    assign r1_res_valid = !empty[1];
    assign r0_res_x = empty[0] ? '0 : mem_x[0][rp[0][aw-1:0]];
    assign r0_res_y = empty[0] ? '0 : mem_y[0][rp[0][aw-1:0]];
    assign r1_res_x = empty[1] ? '0 : mem_x[1][rp[1][aw-1:0]];
    assign r1_res_y = empty[1] ? '0 : mem_y[1][rp[1][aw-1:0]];
    assign busy = |tag_v || empty != 2'b11;

    // credits count free result slots; FIFO pointers wrap modulo 2*res_depth
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            for (int i = 0; i < 2; i++) begin
                credit[i] <= cw'(res_depth);
                wp[i] <= '0;
                rp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                credit[i] <= credit[i] - cw'(hs[i]) + cw'(pop[i]);
                wp[i] <= wp[i] + cw'(wr[i]);
                rp[i] <= rp[i] + cw'(pop[i]);
            end
        end

    // result storage needs no reset because reads are masked while empty
    always_ff @(posedge clk)
        for (int i = 0; i < 2; i++)
            if (wr[i]) begin
                mem_x[i][wp[i][aw-1:0]] <= core_x_out;
                mem_y[i][wp[i][aw-1:0]] <= core_y_out;
            end

    // tag retires one edge after the core output becomes valid, so the FIFO captures a settled result
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            tag_v <= '0;
            tag_id <= '0;
        end else begin
            tag_v <= {tag_v[pipe_latency-1:0], |hs};
            tag_id <= {tag_id[pipe_latency-1:0], hs[1]};
        end

    // core operands are registered on a handshake and held otherwise
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            core_enable <= 1'b0;
            core_x_in <= '0;
            core_y_in <= '0;
            core_angle <= '0;
        end else begin
            core_enable <= 1'b1;
            if (|hs) begin
                core_x_in <= hs[1] ? r1_x : r0_x;
                core_y_in <= hs[1] ? r1_y : r0_y;
                core_angle <= hs[1] ? r1_angle : r0_angle;
            end
        end
endmodule
